jpeg_hex_stream_packer: RTL and testbench

//  Accepts the ASCII hex dump of a JPEG file one character per beat. Discards whitespace, pairs nibbles into bytes,

---
 rtl/jpeg_pkg.sv | 34 +++
 rtl/jpeg_sync_fifo.sv | 60 ++++++
 rtl/jpeg_hex_stream_packer.sv | 197 +++++++++++++++++++
 tb/tb_jpeg_hex_stream_packer.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_pkg.sv
// Shared types and helpers for the JPEG hex-dump stream packer.
//   char_class_e : classification of an incoming ASCII character
//   byte_state_e : byte-level marker / stuffing state
//   classify()   : ASCII -> character class
//   hex_nibble() : ASCII hex digit -> 4-bit value (only meaningful for CC_HEX)
package jpeg_pkg;

  typedef enum logic [1:0] {CC_HEX, CC_WS, CC_BAD} char_class_e;
  typedef enum logic [1:0] {ST_NORMAL, ST_AFTER_FF, ST_DONE} byte_state_e;

  localparam logic [7:0] MARKER_PREFIX = 8'hFF;
  localparam logic [7:0] MARKER_EOI    = 8'hD9;
  localparam logic [7:0] MARKER_SOI    = 8'hD8;
  localparam logic [7:0] STUFF_BYTE    = 8'h00;

  function automatic char_class_e classify(input logic [7:0] c);
    if ((c >= 8'h30 && c <= 8'h39) ||
        (c >= 8'h41 && c <= 8'h46) ||
        (c >= 8'h61 && c <= 8'h66))
      return CC_HEX;
    if (c == 8'h20 || c == 8'h09 || c == 8'h0A || c == 8'h0D)
      return CC_WS;
    return CC_BAD;
  endfunction

  function automatic logic [3:0] hex_nibble(input logic [7:0] c);
    logic [7:0] v;
    if (c <= 8'h39)      v = c - 8'h30;
    else if (c >= 8'h61) v = c - 8'h57;
    else                 v = c - 8'h37;
    return v[3:0];
  endfunction

endpackage

// File: rtl/jpeg_sync_fifo.sv
// First-word-fall-through synchronous FIFO.
//   clk, rst_n (async, active-low), clear (sync soft clear)
//   push/din  : write when push && !full
//   pop/dout  : dout shows the head word whenever !empty; pop advances it
//   full/empty: occupancy flags
module jpeg_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/jpeg_hex_stream_packer.sv
// JPEG hex-dump stream packer.
// Takes ASCII hex characters one per beat, skips whitespace, flags illegal
// characters, pairs nibbles into bytes, optionally removes 0xFF00 stuffing,
// reports markers and packs bytes MSB-lane-first into OUT_BYTES-wide words
// queued in a FWFT FIFO.
//   in_valid/in_ready/in_char   : character input handshake
//   out_valid/out_ready         : output word handshake (FIFO head)
//   out_data/out_keep/out_last  : packed word, lane-valid mask, EOI flag
//   marker_pulse/marker_code    : marker strobe and its second byte
//   fmt_err                     : sticky illegal-character flag
//   eoi_done                    : EOI word has been queued
//   byte_cnt                    : bytes emitted into the packer (wraps)
module jpeg_hex_stream_packer
  import jpeg_pkg::*;
#(
  parameter int unsigned OUT_BYTES   = 4,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter bit          STRIP_STUFF = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7:0]             in_char,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [8*OUT_BYTES-1:0] out_data,
  output logic [OUT_BYTES-1:0]   out_keep,
  output logic                   out_last,
  output logic                   marker_pulse,
  output logic [7:0]             marker_code,
  output logic                   fmt_err,
  output logic                   eoi_done,
  output logic [31:0]            byte_cnt
);

  localparam int unsigned DW = 8 * OUT_BYTES;
  localparam int unsigned FW = DW + OUT_BYTES + 1;
  localparam int unsigned CW = $clog2(OUT_BYTES + 1);

  byte_state_e    state;
  byte_state_e    next_state;
  logic           nib_lo;
  logic [3:0]     hi_nib;
  logic [DW-1:0]  pack_data;
  logic [CW-1:0]  pack_cnt;

  char_class_e    cls;
  logic [3:0]     nib;
  logic [7:0]     cur_byte;
  logic           accept;
  logic           byte_done;
  logic           emit;
  logic           is_marker;
  logic           is_eoi;

  logic [DW-1:0]        word_data;
  logic [OUT_BYTES-1:0] word_keep;
  logic [CW-1:0]        fill;
  logic                 word_full;
  logic                 push;

  logic [FW-1:0]  fifo_dout;
  logic           fifo_full;
  logic           fifo_empty;

  assign in_ready  = !fifo_full && (state != ST_DONE);
  assign accept    = in_valid && in_ready;
  assign cls       = classify(in_char);
  assign nib       = hex_nibble(in_char);
  assign cur_byte  = {hi_nib, nib};
  assign byte_done = accept && (cls == CC_HEX) && nib_lo;

  always_comb begin
    emit       = 1'b0;
    is_marker  = 1'b0;
    is_eoi     = 1'b0;
    next_state = state;
    case (state)
      ST_NORMAL: begin
        emit = 1'b1;
        if (cur_byte == MARKER_PREFIX) next_state = ST_AFTER_FF;
      end
      ST_AFTER_FF: begin
        if (cur_byte == STUFF_BYTE) begin
          emit       = ~STRIP_STUFF;
          next_state = ST_NORMAL;
        end else if (cur_byte == MARKER_PREFIX) begin
          emit = 1'b1;
        end else begin
          emit      = 1'b1;
          is_marker = 1'b1;
          if (cur_byte == MARKER_EOI) begin
            is_eoi     = 1'b1;
            next_state = ST_DONE;
          end else begin
            next_state = ST_NORMAL;
          end
        end
      end
      default: ;
    endcase
  end

  // The incoming byte lands in lane pack_cnt counted from the MSB end;
  // keep is a run of leading ones covering every lane filled so far.
  always_comb begin
    word_data = pack_data;
    for (int unsigned i = 0; i < OUT_BYTES; i++) begin
      if (CW'(i) == pack_cnt) word_data[8*(OUT_BYTES-i)-1 -: 8] = cur_byte;
    end
    fill      = pack_cnt + CW'(1);
    word_keep = ~({OUT_BYTES{1'b1}} >> fill);
    word_full = (pack_cnt == CW'(OUT_BYTES - 1));
    push      = byte_done && emit && (word_full || is_eoi);
  end

  jpeg_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .push  (push),
    .din   ({is_eoi, word_keep, word_data}),
    .pop   (out_ready),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_empty ? '0 : fifo_dout[DW-1:0];
  assign out_keep  = fifo_empty ? '0 : fifo_dout[DW +: OUT_BYTES];
  assign out_last  = fifo_empty ? 1'b0 : fifo_dout[FW-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_NORMAL;
      nib_lo       <= 1'b0;
      hi_nib       <= '0;
      pack_data    <= '0;
      pack_cnt     <= '0;
      marker_pulse <= 1'b0;
      marker_code  <= '0;
      fmt_err      <= 1'b0;
      eoi_done     <= 1'b0;
      byte_cnt     <= '0;
    end else if (clear) begin
      state        <= ST_NORMAL;
      nib_lo       <= 1'b0;
      hi_nib       <= '0;
      pack_data    <= '0;
      pack_cnt     <= '0;
      marker_pulse <= 1'b0;
      marker_code  <= '0;
      fmt_err      <= 1'b0;
      eoi_done     <= 1'b0;
      byte_cnt     <= '0;
    end else begin
      marker_pulse <= 1'b0;
      if (accept) begin
        if (cls == CC_BAD) begin
          fmt_err <= 1'b1;
        end else if (cls == CC_HEX) begin
          if (!nib_lo) begin
            hi_nib <= nib;
            nib_lo <= 1'b1;
          end else begin
            nib_lo <= 1'b0;
          end
        end
      end
      if (byte_done) begin
        state <= next_state;
        if (is_marker) begin
          marker_pulse <= 1'b1;
          marker_code  <= cur_byte;
        end
        if (emit) begin
          byte_cnt <= byte_cnt + 32'd1;
          if (push) begin
            pack_data <= '0;
            pack_cnt  <= '0;
            if (is_eoi) eoi_done <= 1'b1;
          end else begin
            pack_data <= word_data;
            pack_cnt  <= pack_cnt + CW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_jpeg_hex_stream_packer.sv
module tb_jpeg_hex_stream_packer;

  localparam int SW = 160;
  typedef logic [SW-1:0] vec_t;
  typedef struct packed {logic last; logic [3:0] keep; logic [31:0] data;} word_t;

  typedef struct {
    vec_t        stim;
    int          nw;
    logic [31:0] d0, d1;
    logic [3:0]  k0, k1;
    logic        l0, l1;
    int          nm;
    logic [7:0]  m0, m1;
    int          bc;
    logic        fe, eo, rdy;
  } vec_rec_t;

  logic clk = 0, rst_n = 0, clear = 0;
  logic in_valid = 0, in_ready, out_valid, out_ready = 0;
  logic [7:0] in_char = 0;
  logic [31:0] out_data, byte_cnt;
  logic [3:0] out_keep;
  logic out_last, marker_pulse, fmt_err, eoi_done;
  logic [7:0] marker_code;

  logic b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 1;
  logic [7:0] b_in_char = 0;
  logic [31:0] b_out_data, b_byte_cnt;
  logic [3:0] b_out_keep;
  logic b_out_last, b_marker_pulse, b_fmt_err, b_eoi_done;
  logic [7:0] b_marker_code;

  jpeg_hex_stream_packer #(.OUT_BYTES(4), .FIFO_DEPTH(8), .STRIP_STUFF(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_char(in_char), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_keep(out_keep), .out_last(out_last), .marker_pulse(marker_pulse),
    .marker_code(marker_code), .fmt_err(fmt_err), .eoi_done(eoi_done), .byte_cnt(byte_cnt));

  jpeg_hex_stream_packer #(.OUT_BYTES(4), .FIFO_DEPTH(8), .STRIP_STUFF(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_char(b_in_char), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_keep(b_out_keep), .out_last(b_out_last), .marker_pulse(b_marker_pulse),
    .marker_code(b_marker_code), .fmt_err(b_fmt_err), .eoi_done(b_eoi_done), .byte_cnt(b_byte_cnt));

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int rd_mode = 1;
  word_t got[$], got_b[$], exp_w[$];
  logic [7:0] mk[$], exp_m[$];
  int exp_bc;
  logic exp_fe, exp_eoi;

  // out_ready is set here, so a capture at this negedge matches the pop at the next posedge.
  always @(negedge clk) begin
    case (rd_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
    if (out_valid && out_ready) got.push_back({out_last, out_keep, out_data});
    if (marker_pulse) mk.push_back(marker_code);
    if (b_out_valid && b_out_ready) got_b.push_back({b_out_last, b_out_keep, b_out_data});
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic send_char(input bit sel, input logic [7:0] c);
    int t = 0;
    if (sel) begin b_in_valid = 1; b_in_char = c; end
    else begin in_valid = 1; in_char = c; end
    while (!(sel ? b_in_ready : in_ready) && t < 2000) begin @(negedge clk); t++; end
    if (!(sel ? b_in_ready : in_ready)) begin
      total++; bad++;
      $display("FAIL accept_timeout: char %0h not accepted", c);
    end
    @(negedge clk);
    in_valid = 0;
    b_in_valid = 0;
  endtask

  task automatic send_vec(input bit sel, input vec_t v);
    logic [7:0] c;
    for (int i = SW/8 - 1; i >= 0; i--) begin
      c = v[8*i +: 8];
      if (c != 8'h00) send_char(sel, c);
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 600 && (out_valid || b_out_valid); t++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  task automatic do_clear();
    clear = 1;
    @(negedge clk);
    clear = 0;
    got.delete(); got_b.delete(); mk.delete();
  endtask

  function automatic bit tb_is_hex(input logic [7:0] c);
    return (c >= "0" && c <= "9") || (c >= "a" && c <= "f") || (c >= "A" && c <= "F");
  endfunction

  function automatic logic [7:0] tb_hexval(input logic [7:0] c);
    if (c >= "0" && c <= "9") return c - 8'd48;
    if (c >= "a" && c <= "f") return c - 8'd87;
    return c - 8'd55;
  endfunction

  // Reference: list of chars -> list of nibbles -> bytes -> kept bytes -> words.
  function automatic void model(input logic [7:0] chars[$], input bit strip);
    logic [7:0] nibs[$], bytes[$], kept[$];
    logic [7:0] b;
    bit after;
    int nfull, rem;
    logic [31:0] d;
    exp_w.delete(); exp_m.delete();
    exp_fe = 0; exp_eoi = 0;
    foreach (chars[i]) begin
      if (tb_is_hex(chars[i])) nibs.push_back(tb_hexval(chars[i]));
      else if (!(chars[i] == 8'h20 || chars[i] == 8'h09 || chars[i] == 8'h0A || chars[i] == 8'h0D)) exp_fe = 1;
    end
    for (int i = 0; i + 1 < nibs.size(); i += 2) bytes.push_back(nibs[i] * 16 + nibs[i+1]);
    for (int i = 0; i < bytes.size() && !exp_eoi; i++) begin
      b = bytes[i];
      after = (i > 0) && (bytes[i-1] == 8'hFF);
      if (after && b == 8'h00) begin
        if (!strip) kept.push_back(b);
      end else begin
        kept.push_back(b);
        if (after && b != 8'hFF) begin
          exp_m.push_back(b);
          if (b == 8'hD9) exp_eoi = 1;
        end
      end
    end
    exp_bc = kept.size();
    nfull = kept.size() / 4;
    rem = kept.size() % 4;
    for (int k = 0; k < nfull; k++) begin
      d = {kept[4*k], kept[4*k+1], kept[4*k+2], kept[4*k+3]};
      exp_w.push_back({exp_eoi && rem == 0 && k == nfull - 1, 4'hF, d});
    end
    if (exp_eoi && rem != 0) begin
      d = 0;
      for (int j = 0; j < rem; j++) d = d | (32'(kept[4*nfull+j]) << (24 - 8*j));
      exp_w.push_back({1'b1, 4'(4'hF << (4 - rem)), d});
    end
  endfunction

  task automatic run_random(input int n, input int iter);
    logic [7:0] bytes[$], chars[$];
    logic [7:0] b, prev, nb;
    int r;
    prev = 0;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 99);
      if (r < 15) b = 8'hFF;
      else if (prev == 8'hFF && r < 45) b = 8'h00;
      else b = 8'($urandom);
      if (prev == 8'hFF && b == 8'hD9) b = 8'hD8;
      bytes.push_back(b);
      prev = b;
    end
    bytes.push_back(8'hFF);
    bytes.push_back(8'hD9);
    foreach (bytes[i]) begin
      for (int h = 1; h >= 0; h--) begin
        nb = 8'((bytes[i] >> (4*h)) & 8'h0F);
        if (nb < 10) chars.push_back(8'h30 + nb);
        else chars.push_back((($urandom_range(0, 1) == 1) ? 8'h41 : 8'h61) + nb - 8'd10);
        r = $urandom_range(0, 99);
        if (r < 4) chars.push_back(8'h47);
        else if (r < 8) chars.push_back(8'h23);
        else if (r < 14) chars.push_back(8'h20);
        else if (r < 17) chars.push_back(8'h0A);
      end
    end
    model(chars, 1'b1);
    do_clear();
    rd_mode = 2;
    foreach (chars[i]) send_char(0, chars[i]);
    drain();
    check($sformatf("rnd%0d_nwords", iter), got.size(), exp_w.size());
    for (int i = 0; i < exp_w.size(); i++)
      if (i < got.size()) check($sformatf("rnd%0d_word%0d", iter, i), got[i], exp_w[i]);
    check($sformatf("rnd%0d_nmarkers", iter), mk.size(), exp_m.size());
    for (int i = 0; i < exp_m.size(); i++)
      if (i < mk.size()) check($sformatf("rnd%0d_marker%0d", iter, i), mk[i], exp_m[i]);
    check($sformatf("rnd%0d_byte_cnt", iter), byte_cnt, exp_bc);
    check($sformatf("rnd%0d_fmt_err", iter), fmt_err, exp_fe);
    check($sformatf("rnd%0d_eoi_done", iter), eoi_done, 1);
    check($sformatf("rnd%0d_in_ready", iter), in_ready, 0);
    rd_mode = 1;
  endtask

  task automatic abort_test(input bit use_reset, input string tag);
    do_clear();
    send_vec(0, vec_t'("AB C"));
    if (use_reset) rst_n = 0; else clear = 1;
    @(negedge clk);
    rst_n = 1; clear = 0;
    @(negedge clk);
    got.delete(); mk.delete();
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_byte_cnt0"}, byte_cnt, 0);
    check({tag, "_in_ready"}, in_ready, 1);
    send_vec(0, vec_t'("DE"));
    drain();
    check({tag, "_no_output"}, got.size(), 0);
    check({tag, "_byte_cnt1"}, byte_cnt, 1);
    send_vec(0, vec_t'("ADBEEF"));
    drain();
    check({tag, "_nwords"}, got.size(), 1);
    if (got.size() > 0) check({tag, "_word"}, got[0], {1'b0, 4'hF, 32'hDEADBEEF});
  endtask

  vec_rec_t tv[4];

  initial begin
    tv[0] = '{vec_t'("FF D8 FF E0"), 1, 32'hFFD8FFE0, 0, 4'hF, 0, 0, 0, 2, 8'hD8, 8'hE0, 4, 0, 0, 1};
    tv[1] = '{vec_t'("12\n3 4\r\n56 78"), 1, 32'h12345678, 0, 4'hF, 0, 0, 0, 0, 0, 0, 4, 0, 0, 1};
    tv[2] = '{vec_t'("AB FF 00 CD FF D9"), 2, 32'hABFFCDFF, 32'hD9000000, 4'hF, 4'h8, 0, 1,
              1, 8'hD9, 0, 5, 0, 1, 0};
    tv[3] = '{vec_t'("1G2 345678"), 1, 32'h12345678, 0, 4'hF, 0, 0, 0, 0, 0, 0, 4, 1, 0, 1};

    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_data", out_data, 0);
    check("rst_byte_cnt", byte_cnt, 0);
    check("rst_flags", {fmt_err, eoi_done, marker_pulse, out_last}, 0);
    check("rst_marker_code", marker_code, 0);

    for (int i = 0; i < 4; i++) begin
      do_clear();
      send_vec(0, tv[i].stim);
      drain();
      check($sformatf("tv%0d_nwords", i), got.size(), tv[i].nw);
      if (tv[i].nw > 0 && got.size() > 0)
        check($sformatf("tv%0d_word0", i), got[0], {tv[i].l0, tv[i].k0, tv[i].d0});
      if (tv[i].nw > 1 && got.size() > 1)
        check($sformatf("tv%0d_word1", i), got[1], {tv[i].l1, tv[i].k1, tv[i].d1});
      check($sformatf("tv%0d_nmarkers", i), mk.size(), tv[i].nm);
      if (tv[i].nm > 0 && mk.size() > 0) check($sformatf("tv%0d_marker0", i), mk[0], tv[i].m0);
      if (tv[i].nm > 1 && mk.size() > 1) check($sformatf("tv%0d_marker1", i), mk[1], tv[i].m1);
      check($sformatf("tv%0d_byte_cnt", i), byte_cnt, tv[i].bc);
      check($sformatf("tv%0d_fmt_err", i), fmt_err, tv[i].fe);
      check($sformatf("tv%0d_eoi_done", i), eoi_done, tv[i].eo);
      check($sformatf("tv%0d_in_ready", i), in_ready, tv[i].rdy);
    end

    do_clear();
    send_vec(1, vec_t'("AB FF 00 CD FF D9"));
    drain();
    check("nostrip_nwords", got_b.size(), 2);
    if (got_b.size() > 0) check("nostrip_word0", got_b[0], {1'b0, 4'hF, 32'hABFF00CD});
    if (got_b.size() > 1) check("nostrip_word1", got_b[1], {1'b1, 4'hC, 32'hFFD90000});
    check("nostrip_byte_cnt", b_byte_cnt, 6);
    check("nostrip_eoi_done", b_eoi_done, 1);
    check("nostrip_in_ready", b_in_ready, 0);

    do_clear();
    rd_mode = 0;
    for (int i = 1; i <= 32; i++) begin
      send_char(0, tb_is_hex(8'h30 + 8'(i / 16)) ? 8'h30 + 8'(i / 16) : 8'h30);
      send_char(0, (i % 16) < 10 ? 8'h30 + 8'(i % 16) : 8'h41 + 8'(i % 16 - 10));
    end
    check("bp_in_ready_low", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    check("bp_byte_cnt", byte_cnt, 32);
    repeat (4) @(negedge clk);
    check("bp_still_blocked", in_ready, 0);
    rd_mode = 1;
    for (int i = 33; i <= 40; i++) begin
      send_char(0, 8'h30 + 8'(i / 16));
      send_char(0, (i % 16) < 10 ? 8'h30 + 8'(i % 16) : 8'h41 + 8'(i % 16 - 10));
    end
    drain();
    check("bp_nwords", got.size(), 10);
    for (int k = 0; k < 10; k++)
      if (k < got.size())
        check($sformatf("bp_word%0d", k), got[k],
              {1'b0, 4'hF, 8'(4*k+1), 8'(4*k+2), 8'(4*k+3), 8'(4*k+4)});
    check("bp_byte_cnt_final", byte_cnt, 40);

    abort_test(1'b1, "abort_rst");
    abort_test(1'b0, "abort_clr");

    for (int it = 0; it < 3; it++) run_random(40 + 10 * it, it);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
